tone_capture: RTL
=================

// Module: tone_capture
// PURPOSE
//  Receive-side counterpart of the SoC piezo tone driver: measures the half-period of an
//  external square wave (mic comparator, sensor, loopback of the piezo pin). Reports it in
//  clock cycles, in the same encoding as the driver's compare value.
//  A value read here, written back to the driver, reproduces the tone.
//  Sits on the SoC peripheral bus with a Write/Read strobe and Ready handshake.
// PARAMETERS
//  WIDTH        24  counter/capture width in bits; legal range 8..29.
//  SYNC_STAGES  2   flip-flop stages on Tone_In before edge detection; minimum 2.
// PORTS
//  clock     in   1      system clock; single clock domain.
//  reset     in   1      synchronous, active-high reset.
//  Tone_In   in   1      asynchronous square-wave input.
//  data_in   in   2      control word: [0] enable, [1] clear capture/flags.
//  Write     in   1      one-cycle strobe; loads data_in.
//  Read      in   1      one-cycle strobe; samples status/capture into data_out.
//  data_out  out  32     read data: [31] Valid, [30] Overflow, [29] Enabled, [WIDTH-1:0] capture; other bits 0.
//  Ready     out  1      one-cycle acknowledge of Write or Read.
// BEHAVIOUR
//  Reset: all registers are zero, including data_out and Ready. State is IDLE.
//  Front end: Tone_In passes through SYNC_STAGES flops, then one more flop for edge detection.
//   edge = sync XOR prev. Both rising and falling edges count.
//  State machine:
//   IDLE: counter is held at 0; edges are ignored. Write with enable=1 moves to ARMED.
//   ARMED: waits for the first edge. On that edge, counter is set to 0 and the state moves to MEASURE.
//    Nothing is captured in ARMED.
//   MEASURE: counter increments by 1 each cycle. On an edge, capture <= counter, Valid <= 1,
//    and counter <= 0 in the same cycle.
//    Counter semantics: N cycles between edges means captured value N-1.
//    A driver with compare=C therefore captures as C.
//   Timeout: counter at 2^WIDTH-1 with no edge sets capture <= all-ones, Overflow <= 1,
//    Valid <= 1, and the state goes to ARMED (tone has stopped).
//   Edge coincident with counter at max: normal capture of all-ones; Overflow is not set;
//    state stays MEASURE.
//   Write with enable=0, from any state: go to IDLE and zero the counter. Capture, Valid and
//    Overflow are retained.
//  Clear (Write with data_in[1]=1): capture, Valid and Overflow go to 0.
//   A capture in the same cycle wins: new value loaded, Valid=1.
//   Clear and enable are applied together: data_in=2'b11 clears and arms.
//  Read: in cycle N+1, data_out = status/capture as of cycle N, and Ready=1.
//   Valid clears at N+1 (read-to-clear). Overflow is sticky until clear or reset.
//   A capture in cycle N sets Valid again at N+1, and the returned word shows the pre-capture value.
//   data_out holds its value between Reads.
//  Write: Ready=1 in cycle N+1; data_out is unchanged. Read and Write in the same cycle:
//   both take effect, with a single Ready pulse. Ready is never asserted for two cycles
//   from one strobe.
//  Enabled bit reflects state != IDLE.
//  Reset mid-measurement: everything returns to reset values on the next edge of clock.
//   No partial capture is kept.
// STRUCTURE
//  Shared include tone_capture_defs.vh holds the state encoding (IDLE=2'd0, ARMED=2'd1,
//   MEASURE=2'd2) and the data_out bit positions (VALID_BIT=31, OVF_BIT=30, EN_BIT=29).
//   The piezo driver and its software headers use the same include.
//  One sub-module: sync_edge_detect (SYNC_STAGES parameter; outputs sync level and a
//   one-cycle edge pulse). The FSM, counter and bus registers live in the top module.
// TESTING
//  1. Reset, then enable (data_in=01); drive a square wave toggling every 100 clocks.
//     Expect Read -> Valid=1, capture=99, Overflow=0, Enabled=1, Ready for one cycle.
//  2. Loop the piezo driver (compare=0x0003E7, enabled) into Tone_In.
//     Expect capture=0x0003E7. A second Read with no new edge returns Valid=0.
//  3. WIDTH=8, enable, one edge, then hold Tone_In for 300 cycles.
//     Expect capture=0xFF, Overflow=1, Enabled=1, state ARMED.
//     Next edge pair 10 clocks apart gives capture=9, Overflow still 1 until data_in=10 clears it.
//  4. Read asserted in the same cycle as a capture edge: returned word shows the old Valid;
//     the following Read shows Valid=1 with the new value.
//  5. Write data_in=00 mid-measurement: Enabled=0, edges ignored, last capture retained.
//     Write data_in=11 clears and arms; the first edge produces no capture.
//  6. Assert reset during MEASURE with Valid=1: data_out=0, Ready=0, Enabled=0 next cycle.
//     Glitch pulses shorter than a clock do not produce spurious edges in the scoreboard.

Source files
------------

// File: rtl/tone_capture_pkg.sv
// Shared definitions for the tone capture block.
// The state encoding and the data_out bit positions match the piezo tone driver
// and its software headers, so status words can be decoded the same way on both sides.
package tone_capture_pkg;

  // Measurement state machine encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

  // data_out status bit positions
  localparam int VALID_BIT = 31;
  localparam int OVF_BIT   = 30;
  localparam int EN_BIT    = 29;

  // data_in control bit positions
  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  // Widest capture field that still fits below the status bits
  localparam int CAP_FIELD_W = 29;

  // Assemble the read word from status flags and a zero-extended capture field
  function automatic logic [31:0] pack_status(input logic               valid,
                                              input logic               ovf,
                                              input logic               en,
                                              input logic [CAP_FIELD_W-1:0] cap);
    logic [31:0] w;
    w                 = '0;
    w[CAP_FIELD_W-1:0] = cap;
    w[VALID_BIT]      = valid;
    w[OVF_BIT]        = ovf;
    w[EN_BIT]         = en;
    return w;
  endfunction

endpackage

// File: rtl/tone_capture_sync_edge_detect.sv
// Synchroniser plus edge detector for the asynchronous tone input.
// Tone_In passes through SYNC_STAGES flops, then one more flop holds the previous
// synchronised level. Any change of level (rising or falling) produces a one-cycle pulse.
// Pulses narrower than a clock period are normally never sampled and so never seen.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;

  // Shift the raw input along the synchroniser chain and remember the last settled level
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and history flops
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_out   = sync_q[SYNC_STAGES-1];
  assign edge_pulse = sync_out ^ prev_q;

endmodule

// File: rtl/tone_capture.sv
// Tone capture: measures the half-period of an external square wave in clock cycles.
// Encoding matches the piezo driver compare value: a half-period of C+1 clocks reads as C.
//
// Bus handshake: Write and Read are one-cycle strobes sampled on a rising clock edge
// (cycle N). Ready is a one-cycle acknowledge in cycle N+1, a single pulse even when
// Read and Write arrive together. For a Read, data_out in N+1 holds the status and
// capture as they stood in cycle N; data_out keeps that value until the next Read.
module tone_capture
  import tone_capture_pkg::*;
#(
  parameter int WIDTH       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Tone_In,
  input  logic [1:0]  data_in,
  input  logic        Write,
  input  logic        Read,
  output logic [31:0] data_out,
  output logic        Ready,
  output logic [1:0]  state_dbg,
  output logic        tone_level
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  // Front end outputs
  logic tone_edge;
  logic tone_sync;

  // Architectural state
  state_e            state_q,    state_d;
  logic [WIDTH-1:0]  counter_q,  counter_d;
  logic [WIDTH-1:0]  capture_q,  capture_d;
  logic              valid_q,    valid_d;
  logic              ovf_q,      ovf_d;
  logic [31:0]       data_out_q, data_out_d;
  logic              ready_q,    ready_d;

  // Decoded bus controls and per-cycle capture events
  logic                   wr_enable;
  logic                   wr_disable;
  logic                   wr_clear;
  logic                   cap_load;
  logic                   cap_timeout;
  logic [WIDTH-1:0]       cap_value;
  logic [CAP_FIELD_W-1:0] cap_ext;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk        (clock),
    .rst        (reset),
    .async_in   (Tone_In),
    .sync_out   (tone_sync),
    .edge_pulse (tone_edge)
  );

  // Decode the control word carried by a Write strobe
  always_comb begin
    wr_enable  = Write &  data_in[CTRL_EN_BIT];
    wr_disable = Write & ~data_in[CTRL_EN_BIT];
    wr_clear   = Write &  data_in[CTRL_CLR_BIT];
  end

  // Zero-extend the current capture into the fixed-width read field
  always_comb begin
    cap_ext               = '0;
    cap_ext[WIDTH-1:0]    = capture_q;
  end

  // Next-state logic: FSM, half-period counter, capture/flags and bus read-back
  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    capture_d   = capture_q;
    valid_d     = valid_q;
    ovf_d       = ovf_q;
    data_out_d  = data_out_q;
    ready_d     = Read | Write;
    cap_load    = 1'b0;
    cap_timeout = 1'b0;
    cap_value   = '0;

    case (state_q)
      ST_IDLE: begin
        // Counter parked at zero; edges carry no meaning until armed
        counter_d = '0;
        if (wr_enable) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        // First edge only establishes phase; nothing is captured here
        counter_d = '0;
        if (tone_edge) begin
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (tone_edge) begin
          // An edge at the counter limit is still a normal capture of all-ones
          cap_load  = 1'b1;
          cap_value = counter_q;
          counter_d = '0;
        end else if (counter_q == CNT_MAX) begin
          // Tone has stopped: report all-ones, flag overflow, wait for a new first edge
          cap_load    = 1'b1;
          cap_timeout = 1'b1;
          cap_value   = CNT_MAX;
          counter_d   = '0;
          state_d     = ST_ARMED;
        end else begin
          counter_d = counter_q + WIDTH'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        counter_d = '0;
      end
    endcase

    // Disable wins over any state move; a period completed this cycle is still recorded
    if (wr_disable) begin
      state_d   = ST_IDLE;
      counter_d = '0;
    end

    // Read returns the pre-update view, then Valid is consumed
    if (Read) begin
      data_out_d = pack_status(valid_q, ovf_q, (state_q != ST_IDLE), cap_ext);
      valid_d    = 1'b0;
    end

    if (wr_clear) begin
      capture_d = '0;
      valid_d   = 1'b0;
      ovf_d     = 1'b0;
    end

    // A capture in the same cycle overrides both read-to-clear and an explicit clear
    if (cap_load) begin
      capture_d = cap_value;
      valid_d   = 1'b1;
      if (cap_timeout) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Register all state; reset returns everything to zero and the FSM to IDLE
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      counter_q  <= '0;
      capture_q  <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      data_out_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      capture_q  <= capture_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
    end
  end

  assign data_out   = data_out_q;
  assign Ready      = ready_q;
  assign state_dbg  = state_q;
  assign tone_level = tone_sync;

endmodule
